turn_input_ctrl: RTL
====================

Name: turn_input_ctrl

Overview:
- Per-player input stage upstream of the player/arena logic.
- Converts two raw active-low pushbuttons (counter-clockwise, clockwise) into debounced, edge-detected turn commands.
- Queues the commands and applies at most one per game tick to a registered 2-bit heading.
- The movement logic samples that heading on its next step; one instance per player.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles needed to accept a key level change (5 ms at 50 MHz).
- FIFO_DEPTH, 4: number of queued turn commands; power of two, at least 2.
- INIT_DIR, 0: heading after reset/restart (0 right, 1 down, 2 left, 3 up).
- REPEAT_CYCLES, 12500000: auto-repeat period while a key is held; used only with the optional feature.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- restart  in  1  synchronous round restart, level.
- key_ccw_n  in  1  raw pushbutton, active-low, asynchronous; counter-clockwise turn.
- key_cw_n  in  1  raw pushbutton, active-low, asynchronous; clockwise turn.
- tick  in  1  one-cycle game-step strobe.
- dir  out  2  current heading.
- dir_changed  out  1  one-cycle pulse, the cycle dir updates.
- turn_pending  out  1  FIFO non-empty.
- overflow  out  1  one-cycle pulse when a press is dropped because the FIFO is full.

Behaviour:
- Synchroniser: each key passes through a 2-flop synchroniser; reset value 1 (released).
- Debounce:
  - Per key: a stable level register (reset 1) and a counter (reset 0).
  - If the synchronised level equals the stable level, the counter clears.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Press event: the stable level goes 1->0. Press release produces nothing.
- Command encoding: CCW press pushes 0; CW press pushes 1.
- Both press events in the same cycle: both are ignored; nothing is pushed.
- FIFO:
  - 1-bit entries, FIFO_DEPTH deep, with pointers and a count.
  - Push when full: the entry is dropped and overflow pulses for 1 cycle.
  - Pop only on tick while count>0.
  - Push and pop in the same cycle: both occur, count unchanged, and the new entry queues behind. This is legal even when full, because the pop frees a slot.
- Heading update:
  - On a tick with a pop, the registered dir changes the following cycle: 1-cycle latency from tick.
  - CW gives dir+1 mod 4; CCW gives dir-1 mod 4 (2-bit wrap: 3->0, 0->3).
  - dir_changed pulses the same cycle dir takes the new value.
  - At most one turn per tick. A tick with an empty FIFO leaves dir unchanged with no pulse.
- turn_pending: count!=0, registered.
- restart (synchronous, priority over tick and push):
  - While high: FIFO flushed, dir=INIT_DIR, no pushes, no pulses.
  - Debounce and synchroniser state are kept, so a key held across restart generates no new press.
- reset (asynchronous): dir=INIT_DIR, dir_changed=0, overflow=0, turn_pending=0, FIFO empty, stable levels=1, counters=0. Reset mid-debounce discards the partial count.

Optional Feature:
- Macro TURN_AUTOREPEAT_EN.
- Defined:
  - While a key's stable level stays 0, a per-key repeat counter runs.
  - Every REPEAT_CYCLES after the press it generates an additional press event for that key, subject to the same simultaneity and overflow rules.
  - The counter clears on release, restart and reset.
- Not defined: no repeat logic is built; one command per physical press.

Decomposition:
- Shared package tron_pkg:
  - Heading constants DIR_RIGHT=0, DIR_DOWN=1, DIR_LEFT=2, DIR_UP=3 and a 2-bit dir type.
  - Turn encoding TURN_CCW=0, TURN_CW=1.
  - This package is also used by the movement/arena logic.
- Sub-module key_debounce: synchroniser, debounce counter and press-pulse output, parameterised by DEBOUNCE_CYCLES; instantiated twice.
- The FIFO and heading register stay inline.

Test Plan (bench uses DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, INIT_DIR=0):
- Press key_cw_n low for 10 cycles, release, then tick -> dir becomes 1 one cycle after tick; dir_changed pulses once; turn_pending goes 1 then 0.
- Key bounces (low 2 cycles, high 1, low 2, high) -> no press accepted, FIFO count stays 0; a tick leaves dir=0 with no pulse.
- 5 separate CW presses with no tick -> fifth press pulses overflow; then 5 ticks -> dir goes 1,2,3,0 across the first four ticks and stays 0 on the fifth (wrap verified).
- From dir=0, a CCW press then tick -> dir=3. Both keys pressed in the same debounced cycle -> no push.
- Full FIFO, CW press event coincident with tick -> pop and push both occur, count stays 4, no overflow.
- 2 entries queued, restart high 1 cycle -> dir=INIT_DIR, turn_pending=0; a held key produces no press. Assert reset during a debounce count -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared types and constants for the tron player/arena logic.
package tron_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_RIGHT = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_UP    = 2'd3;

  localparam logic TURN_CCW = 1'b0;
  localparam logic TURN_CW  = 1'b1;

  // Rotate a heading one quarter turn; 2-bit arithmetic gives the 3->0 / 0->3 wrap.
  function automatic dir_t apply_turn(input dir_t d, input logic turn);
    dir_t r;
    if (turn == TURN_CW) r = d + 2'd1;
    else                 r = d - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low pushbutton -> synchronised, debounced press pulse.
// Optional auto-repeat while held: define TURN_AUTOREPEAT_EN.
module key_debounce
  import tron_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_press;

  // Two-flop synchroniser, released (1) out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Stable level flips only after the synchronised level has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    stable_d   = stable_q;
    cnt_d      = '0;
    edge_press = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d   = sync2_q;
        edge_press = stable_q;  // 1->0 transition is a press; release yields nothing
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state register; restart intentionally leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef TURN_AUTOREPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_pulse;

  // Repeat counter runs while the debounced key is held, firing every REPEAT_CYCLES.
  always_comb begin
    rpt_d     = '0;
    rpt_pulse = 1'b0;
    if (!restart && !stable_q) begin
      if (rpt_q == RPT_LAST) rpt_pulse = 1'b1;
      else                   rpt_d     = rpt_q + RPT_W'(1);
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end

  assign press = edge_press | rpt_pulse;
`else
  logic unused_restart;
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
  assign unused_restart = restart;
  assign press = edge_press;
`endif

endmodule

// File: rtl/turn_input_ctrl.sv
// Per-player turn input: two debounced keys -> command FIFO -> one heading update per tick.
// Optional auto-repeat (in key_debounce): define TURN_AUTOREPEAT_EN.
module turn_input_ctrl
  import tron_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH      = 4,
  parameter int INIT_DIR        = 0,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       restart,
  input  logic       key_ccw_n,
  input  logic       key_cw_n,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic       turn_pending,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
  localparam dir_t DIR_INIT = dir_t'(INIT_DIR);

  logic press_ccw, press_cw;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_deb_ccw (
    .clk(CLOCK_50), .rst(reset), .restart(restart), .key_n(key_ccw_n), .press(press_ccw)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_deb_cw (
    .clk(CLOCK_50), .rst(reset), .restart(restart), .key_n(key_cw_n), .press(press_cw)
  );

  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  dir_t                  dir_q, dir_d;
  logic                  dir_changed_q, dir_changed_d;
  logic                  turn_pending_q, turn_pending_d;
  logic                  overflow_q, overflow_d;
  logic                  push_req, push_ok, pop;

  // FIFO push/pop and heading update; restart overrides everything.
  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    dir_changed_d = 1'b0;
    overflow_d    = 1'b0;
    // Simultaneous presses cancel; a lone CW press encodes as TURN_CW.
    push_req      = press_ccw ^ press_cw;
    pop           = tick && (cnt_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push_ok       = push_req && ((cnt_q != FULL) || pop);

    if (restart) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      dir_d    = DIR_INIT;
    end else begin
      overflow_d = push_req && !push_ok;
      if (push_ok) begin
        mem_d[wr_ptr_q] = press_cw ? TURN_CW : TURN_CCW;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        dir_d         = apply_turn(dir_q, mem_q[rd_ptr_q]);
        dir_changed_d = 1'b1;
        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push_ok) cnt_d = cnt_q - CNT_W'(1);
    end
    turn_pending_d = (cnt_d != '0);
  end

  // FIFO, heading and status registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      mem_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      dir_q          <= DIR_INIT;
      dir_changed_q  <= 1'b0;
      turn_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      dir_changed_q  <= dir_changed_d;
      turn_pending_q <= turn_pending_d;
      overflow_q     <= overflow_d;
    end
  end

  assign dir          = dir_q;
  assign dir_changed  = dir_changed_q;
  assign turn_pending = turn_pending_q;
  assign overflow     = overflow_q;

endmodule
